// File: rtl/frame_bank_pkg.sv
// Shared definitions for the frame bank manager.
//   bank_state_e : per-bank ownership state
//   MODE_*       : delivery policy selectors for frame_bank_manager.MODE
//   sat_inc      : saturating increment for the statistics counters
package frame_bank_pkg;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_READY   = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  localparam int MODE_LATEST  = 0;
  localparam int MODE_INORDER = 1;

  localparam int MAX_CNT_W = 32;

  // Increment a counter that is 'width' bits wide, sticking at all ones.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int                   width);
    logic [MAX_CNT_W-1:0] max_val;
    max_val = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/ready_bank_queue.sv
// Circular FIFO of bank indices holding READY banks in age order.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : empty the queue (dominates every other operation)
//   push        : write push_data at the tail
//   pop_head    : discard the oldest entry
//   pop_tail    : discard the newest entry (after any same-cycle push)
//   head_data   : oldest entry, tail_data : newest entry (valid when !empty)
//   count, empty: occupancy
module ready_bank_queue #(
  parameter int DEPTH = 3,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] push_data,
  input  logic             pop_head,
  input  logic             pop_tail,
  output logic [IDX_W-1:0] head_data,
  output logic [IDX_W-1:0] tail_data,
  output logic [IDX_W:0]   count,
  output logic             empty
);

  logic [IDX_W-1:0] slot_mem [DEPTH];
  logic [IDX_W-1:0] head_ptr_reg;
  logic [IDX_W-1:0] tail_ptr_reg;
  logic [IDX_W:0]   count_reg;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_dec(input logic [IDX_W-1:0] p);
    return (p == '0) ? IDX_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      slot_mem[tail_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      // push followed by pop_tail removes the entry just pushed: tail stays put
      case ({push, pop_tail})
        2'b10:   tail_ptr_reg <= ptr_inc(tail_ptr_reg);
        2'b01:   tail_ptr_reg <= ptr_dec(tail_ptr_reg);
        default: tail_ptr_reg <= tail_ptr_reg;
      endcase
      if (pop_head) begin
        head_ptr_reg <= ptr_inc(head_ptr_reg);
      end
      count_reg <= count_reg + (IDX_W+1)'(push) - (IDX_W+1)'(pop_head)
                             - (IDX_W+1)'(pop_tail);
    end
  end

  assign head_data = slot_mem[head_ptr_reg];
  assign tail_data = slot_mem[ptr_dec(tail_ptr_reg)];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/frame_bank_manager.sv
// N-bank frame-buffer arbiter between a frame writer and a frame reader.
//   clk, rst_n        : clock, synchronous active-low reset
//   enable            : gates both done pulses
//   frame_write_done  : writer finished a frame (1-cycle pulse)
//   frame_read_done   : reader finished a frame (1-cycle pulse)
//   wr_bank, rd_bank  : banks owned by writer / reader
//   wr_load, rd_load  : 1-cycle start-address reload pulses
//   wr_stall          : INORDER only, writer has no bank
//   ready_cnt         : number of READY banks
//   drop_cnt          : frames discarded unread (saturating)
//   repeat_cnt        : reads restarted on the same bank (saturating)
module frame_bank_manager
  import frame_bank_pkg::*;
#(
  parameter int NUM_BANKS = 3,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int MODE      = MODE_LATEST,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic              wr_stall,
  output logic [BANK_W:0]   ready_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  if (NUM_BANKS < 3) begin : g_bad_num_banks
    $error("frame_bank_manager: NUM_BANKS must be at least 3");
  end
  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
    $error("frame_bank_manager: CNT_W must be 1..32");
  end
  if (MODE != MODE_LATEST && MODE != MODE_INORDER) begin : g_bad_mode
    $error("frame_bank_manager: MODE must be 0 or 1");
  end

  bank_state_e       bank_state_reg  [NUM_BANKS];
  bank_state_e       bank_state_next [NUM_BANKS];
  logic [BANK_W-1:0] wr_bank_reg, wr_bank_next;
  logic [BANK_W-1:0] rd_bank_reg, rd_bank_next;
  logic              wr_load_reg, wr_load_next;
  logic              rd_load_reg, rd_load_next;
  logic              wr_stall_reg, wr_stall_next;
  logic [BANK_W:0]   ready_cnt_reg, ready_cnt_next;
  logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0]  repeat_cnt_reg, repeat_cnt_next;

  logic              q_flush, q_push, q_pop_head, q_pop_tail;
  logic [BANK_W-1:0] q_push_data, q_head_data, q_tail_data;
  logic [BANK_W:0]   q_count;
  logic              q_empty;

  // Queue contents as seen after the write half of the update, so the read
  // half can act on a bank pushed in the same cycle.
  logic [BANK_W-1:0] view_head, view_tail;
  logic [BANK_W:0]   view_cnt;
  logic              free_found;
  logic [BANK_W-1:0] free_idx, new_rd, freed;
  logic              wr_accept, rd_accept;

  assign wr_accept = enable && frame_write_done && !wr_stall_reg;
  assign rd_accept = enable && frame_read_done;

  ready_bank_queue #(
    .DEPTH (NUM_BANKS),
    .IDX_W (BANK_W)
  ) u_ready_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (q_flush),
    .push      (q_push),
    .push_data (q_push_data),
    .pop_head  (q_pop_head),
    .pop_tail  (q_pop_tail),
    .head_data (q_head_data),
    .tail_data (q_tail_data),
    .count     (q_count),
    .empty     (q_empty)
  );

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_state_next[i] = bank_state_reg[i];
    end
    wr_bank_next    = wr_bank_reg;
    rd_bank_next    = rd_bank_reg;
    wr_load_next    = 1'b0;
    rd_load_next    = 1'b0;
    wr_stall_next   = wr_stall_reg;
    drop_cnt_next   = drop_cnt_reg;
    repeat_cnt_next = repeat_cnt_reg;
    q_flush         = 1'b0;
    q_push          = 1'b0;
    q_push_data     = wr_bank_reg;
    q_pop_head      = 1'b0;
    q_pop_tail      = 1'b0;
    view_head       = q_head_data;
    view_tail       = q_tail_data;
    view_cnt        = q_count;
    free_found      = 1'b0;
    free_idx        = '0;
    new_rd          = rd_bank_reg;
    freed           = rd_bank_reg;

    // Write half: finished bank becomes READY, then find the writer a new bank.
    if (wr_accept) begin
      bank_state_next[wr_bank_reg] = BANK_READY;
      q_push = 1'b1;
      if (q_empty) begin
        view_head = wr_bank_reg;
      end
      view_tail = wr_bank_reg;
      view_cnt  = view_cnt + 1'b1;

      // Descending scan so the last hit is the lowest FREE index.
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
        if (bank_state_next[i] == BANK_FREE) begin
          free_found = 1'b1;
          free_idx   = BANK_W'(i);
        end
      end

      if (free_found) begin
        bank_state_next[free_idx] = BANK_WRITING;
        wr_bank_next = free_idx;
        wr_load_next = 1'b1;
      end else if (MODE == MODE_LATEST) begin
        // No FREE bank means at least two READY banks, so the head is never
        // the bank just pushed. view_head goes stale here, but LATEST reads
        // only use the tail.
        q_pop_head = 1'b1;
        bank_state_next[view_head] = BANK_WRITING;
        wr_bank_next  = view_head;
        wr_load_next  = 1'b1;
        drop_cnt_next = CNT_W'(sat_inc(32'(drop_cnt_next), CNT_W));
        view_cnt      = view_cnt - 1'b1;
      end else begin
        wr_stall_next = 1'b1;
      end
    end

    // Read half: sees the queue and FREE set left by the write half.
    if (rd_accept) begin
      rd_load_next = 1'b1;
      if (view_cnt == '0) begin
        repeat_cnt_next = CNT_W'(sat_inc(32'(repeat_cnt_reg), CNT_W));
      end else begin
        freed = rd_bank_reg;
        bank_state_next[freed] = BANK_FREE;
        if (MODE == MODE_LATEST) begin
          new_rd = view_tail;
          for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_state_next[i] == BANK_READY && BANK_W'(i) != new_rd) begin
              bank_state_next[i] = BANK_FREE;
              drop_cnt_next = CNT_W'(sat_inc(32'(drop_cnt_next), CNT_W));
            end
          end
          // Taking the newest and discarding the rest empties the queue.
          q_pop_tail = 1'b1;
          q_flush    = 1'b1;
          view_cnt   = '0;
        end else begin
          new_rd     = view_head;
          q_pop_head = 1'b1;
          view_cnt   = view_cnt - 1'b1;
        end
        bank_state_next[new_rd] = BANK_READING;
        rd_bank_next = new_rd;

        // A stalled writer takes the bank the reader just released.
        if (wr_stall_next) begin
          bank_state_next[freed] = BANK_WRITING;
          wr_bank_next  = freed;
          wr_load_next  = 1'b1;
          wr_stall_next = 1'b0;
        end
      end
    end

    ready_cnt_next = view_cnt;
  end

  genvar gi;
  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    localparam bank_state_e RESET_STATE = (gi == 0)             ? BANK_WRITING :
                                          (gi == NUM_BANKS - 1) ? BANK_READING :
                                                                  BANK_FREE;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bank_state_reg[gi] <= RESET_STATE;
      end else begin
        bank_state_reg[gi] <= bank_state_next[gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_reg    <= '0;
      rd_bank_reg    <= BANK_W'(NUM_BANKS - 1);
      wr_load_reg    <= 1'b0;
      rd_load_reg    <= 1'b0;
      wr_stall_reg   <= 1'b0;
      ready_cnt_reg  <= '0;
      drop_cnt_reg   <= '0;
      repeat_cnt_reg <= '0;
    end else begin
      wr_bank_reg    <= wr_bank_next;
      rd_bank_reg    <= rd_bank_next;
      wr_load_reg    <= wr_load_next;
      rd_load_reg    <= rd_load_next;
      wr_stall_reg   <= wr_stall_next;
      ready_cnt_reg  <= ready_cnt_next;
      drop_cnt_reg   <= drop_cnt_next;
      repeat_cnt_reg <= repeat_cnt_next;
    end
  end

  assign wr_bank    = wr_bank_reg;
  assign rd_bank    = rd_bank_reg;
  assign wr_load    = wr_load_reg;
  assign rd_load    = rd_load_reg;
  assign wr_stall   = wr_stall_reg;
  assign ready_cnt  = ready_cnt_reg;
  assign drop_cnt   = drop_cnt_reg;
  assign repeat_cnt = repeat_cnt_reg;

endmodule
